// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and
// the {instr, pc} channel to decode. master = fetch unit, slave = memory/decoder.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: owns the PC, issues credit-limited memory
// requests, queues returned words and drops wrong-path responses after a redirect.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master          bus
);
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic                  run;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_WIDTH-1:0] resp_pc, resp_pc_n;
  logic [ADDR_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count, count_n;
  logic [CW-1:0]         live, live_n;
  logic [CW-1:0]         drop, drop_n;
  logic [SW-1:0]         credit_used;
  logic                  req_vld, out_vld, accept, pop, push;
  logic                  resp_drop, resp_keep;

  assign target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // Handshake decode; a same-cycle pop frees its slot so a one-cycle memory
  // sustains one word per cycle.
  always_comb begin
    out_vld     = (count != '0) && !redirect_valid;
    pop         = out_vld && bus.out_ready;
    credit_used = SW'(count) + SW'(live) + SW'(drop) - SW'(pop);
    req_vld     = run && !redirect_valid && (credit_used < SW'(QUEUE_DEPTH));
    accept      = req_vld && bus.imem_req_ready;
    resp_drop   = bus.imem_resp_valid && (drop != '0);
    resp_keep   = bus.imem_resp_valid && (drop == '0) && (live != '0);
    push        = resp_keep && !redirect_valid;
  end

  // Next-state; on redirect every still-live request becomes a drop.
  always_comb begin
    fetch_pc_n = fetch_pc;
    resp_pc_n  = resp_pc;
    count_n    = count;
    live_n     = live;
    drop_n     = drop;
    if (redirect_valid) begin
      fetch_pc_n = target;
      resp_pc_n  = target;
      count_n    = '0;
      live_n     = '0;
      drop_n     = drop - CW'(resp_drop) + live - CW'(resp_keep);
    end else begin
      if (accept) fetch_pc_n = fetch_pc + ADDR_WIDTH'(4);
      if (push)   resp_pc_n  = resp_pc + ADDR_WIDTH'(4);
      count_n = count + CW'(push) - CW'(pop);
      live_n  = live + CW'(accept) - CW'(resp_keep);
      drop_n  = drop - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      live     <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run      <= 1'b1;
      fetch_pc <= fetch_pc_n;
      resp_pc  <= resp_pc_n;
      count    <= count_n;
      live     <= live_n;
      drop     <= drop_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Kept responses are sequential from the last redirect, so resp_pc tags them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[wr_ptr] <= bus.imem_resp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = out_vld;
  assign bus.out_instr      = q_instr[rd_ptr];
  assign bus.out_pc         = q_pc[rd_ptr];
endmodule
